// File: rtl/multdiv_ctrl_if.sv
// Handshake and ALU-sharing signals between the execute stage and the multiply/divide sequencer.
interface multdiv_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] alu_opA;
    logic [WIDTH-1:0] alu_opB;
    logic             alu_sub;
    logic [WIDTH-1:0] alu_result;
    logic             alu_isNotEqual;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, alu_result, alu_isNotEqual,
        input  alu_opA, alu_opB, alu_sub, data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, alu_result, alu_isNotEqual,
        output alu_opA, alu_opB, alu_sub, data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_ctrl.sv
// Multi-cycle signed Booth multiply / restoring divide that borrows the execute-stage ALU adder.
// Optional MULTDIV_EARLY_TERM_EN: leave Booth iteration early once the remaining multiplier bits are zero.
module multdiv_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic           clock,
    input logic           reset,
    multdiv_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StIter, StFix, StDone} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             q_q, q_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;

    logic               start, start_div, last_iter, borrow, booth_add;
    logic [1:0]         booth;
    logic [WIDTH-1:0]   shifted, step_hi, abs_a, abs_b;
    logic [WIDTH:0]     upper;
    logic               early_term;
    logic [2*WIDTH-1:0] et_prod;

    assign start     = bus.ctrl_MULT | bus.ctrl_DIV;
    assign start_div = bus.ctrl_DIV & ~bus.ctrl_MULT;
    assign last_iter = cnt_q == CNT_W'(WIDTH - 1);
    assign booth     = {lo_q[0], q_q};
    assign booth_add = booth[1] ^ booth[0];
    assign step_hi   = booth_add ? bus.alu_result : hi_q;
    assign shifted   = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    assign upper     = {hi_q, lo_q[WIDTH-1]};
    assign abs_a     = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
    assign abs_b     = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
    // Borrow out of the unsigned subtract, rebuilt from the operand and result sign bits.
    assign borrow    = (~shifted[WIDTH-1] & m_q[WIDTH-1]) |
                       (~(shifted[WIDTH-1] ^ m_q[WIDTH-1]) & bus.alu_result[WIDTH-1]);

`ifdef MULTDIV_EARLY_TERM_EN
    logic [CNT_W:0] et_sh;
    assign et_sh      = (CNT_W+1)'(WIDTH) - {1'b0, cnt_q};
    assign early_term = (cnt_q != '0) && !q_q && ((lo_q << cnt_q) == '0);
    assign et_prod    = $signed({hi_q, lo_q}) >>> et_sh;
`else
    assign early_term = 1'b0;
    assign et_prod    = '0;
`endif

    // A start pulse takes the ALU so alu_isNotEqual reports divisor != 0 in any state.
    always_comb begin
        bus.alu_opA = bus.data_operandB;
        bus.alu_opB = '0;
        bus.alu_sub = 1'b1;
        if (!start) begin
            if (state_q == StIter && !is_div_q) begin
                bus.alu_opA = hi_q;
                bus.alu_opB = m_q;
                bus.alu_sub = (booth == 2'b10);
            end else if (state_q == StIter) begin
                bus.alu_opA = shifted;
                bus.alu_opB = m_q;
            end else if (state_q == StFix && is_div_q) begin
                bus.alu_opA = '0;
                bus.alu_opB = lo_q;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        q_d      = q_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        m_d      = m_q;
        res_d    = res_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
        unique case (state_q)
            StIter: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) state_d = StFix;
                if (is_div_q) begin
                    hi_d = borrow ? shifted : bus.alu_result;
                    lo_d = {lo_q[WIDTH-2:0], ~borrow};
                end else if (early_term) begin
                    {hi_d, lo_d} = et_prod;
                    q_d          = 1'b0;
                    state_d      = StFix;
                end else begin
                    hi_d = {step_hi[WIDTH-1], step_hi[WIDTH-1:1]};
                    lo_d = {step_hi[0], lo_q[WIDTH-1:1]};
                    q_d  = lo_q[0];
                end
            end
            StFix: begin
                state_d = StDone;
                rdy_d   = 1'b1;
                if (is_div_q) begin
                    res_d = neg_q ? bus.alu_result : lo_q;
                    exc_d = 1'b0;
                end else begin
                    res_d = lo_q;
                    exc_d = !((&upper) || !(|upper));
                end
            end
            StDone:  state_d = StIdle;
            default: ;
        endcase
        if (start) begin
            is_div_d = start_div;
            neg_d    = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            cnt_d    = '0;
            q_d      = 1'b0;
            hi_d     = '0;
            lo_d     = start_div ? abs_a : bus.data_operandB;
            m_d      = start_div ? abs_b : bus.data_operandA;
            state_d  = StIter;
            rdy_d    = 1'b0;
            if (start_div && !bus.alu_isNotEqual) begin
                state_d = StDone;
                res_d   = '0;
                exc_d   = 1'b1;
                rdy_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            q_q      <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            res_q    <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            q_q      <= q_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            m_q      <= m_d;
            res_q    <= res_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign bus.data_result    = res_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = (state_q != StIdle);
endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: arithmetic/latency model plus directed literal vectors.
module tb_multdiv_ctrl;
    localparam int unsigned W = 32;
`ifdef MULTDIV_EARLY_TERM_EN
    localparam bit EarlyEn = 1'b1;
`else
    localparam bit EarlyEn = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    bit   chk_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int unsigned edges = 0;

    multdiv_ctrl_if #(.WIDTH(W)) bus ();

    multdiv_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // The shared ALU lives outside the sequencer.
    assign bus.alu_result     = bus.alu_sub ? bus.alu_opA - bus.alu_opB : bus.alu_opA + bus.alu_opB;
    assign bus.alu_isNotEqual = (bus.alu_opA - bus.alu_opB) != '0;

    always #5 clock = ~clock;
    always @(posedge clock) edges <= edges + 1;

    // Values for the operation being launched, taken by the model on the start edge.
    logic [31:0] nx_res;
    bit          nx_exc;
    int          nx_lat;

    bit          m_pend = 1'b0, m_rdy = 1'b0, m_busy = 1'b0, m_exc = 1'b0, p_exc = 1'b0;
    logic [31:0] m_res = '0, p_res = '0;
    int          m_left = 0;

    function automatic void model_op(input bit mul, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] res, output bit exc, output int lat);
        longint p;
        lat = 33;
        exc = 1'b0;
        if (mul) begin
            p   = longint'($signed(a)) * longint'($signed(b));
            res = p[31:0];
            exc = p != longint'($signed(res));
            if (EarlyEn) begin
                for (int c = 1; c <= 31; c++) begin
                    if ((b >> (c - 1)) == 32'd0) begin
                        lat = c + 2;
                        break;
                    end
                end
            end
        end else if (b == 32'd0) begin
            res = '0;
            exc = 1'b1;
            lat = 0;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res = a;
        end else begin
            res = $signed(a) / $signed(b);
        end
    endfunction

    always @(posedge clock) begin
        if (!reset) begin
            m_pend <= 1'b0;
            m_rdy  <= 1'b0;
            m_busy <= 1'b0;
            m_res  <= '0;
            m_exc  <= 1'b0;
        end else if (bus.ctrl_MULT || bus.ctrl_DIV) begin
            m_busy <= 1'b1;
            if (nx_lat == 0) begin
                m_pend <= 1'b0;
                m_rdy  <= 1'b1;
                m_res  <= nx_res;
                m_exc  <= nx_exc;
            end else begin
                m_pend <= 1'b1;
                m_left <= nx_lat - 1;
                m_rdy  <= 1'b0;
                p_res  <= nx_res;
                p_exc  <= nx_exc;
            end
        end else if (m_pend && m_left == 0) begin
            m_pend <= 1'b0;
            m_rdy  <= 1'b1;
            m_busy <= 1'b1;
            m_res  <= p_res;
            m_exc  <= p_exc;
        end else begin
            if (m_pend) m_left <= m_left - 1;
            m_rdy  <= 1'b0;
            m_busy <= m_pend;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check("model_busy", 32'(bus.busy), 32'(m_busy));
            check("model_rdy", 32'(bus.data_resultRDY), 32'(m_rdy));
            check("model_result", bus.data_result, m_res);
            check("model_exception", 32'(bus.data_exception), 32'(m_exc));
        end
    end

    // Called just after a falling edge; the following rising edge is the start edge.
    task automatic start_op(input bit mul, input bit div, input logic [31:0] a, input logic [31:0] b);
        model_op(mul, a, b, nx_res, nx_exc, nx_lat);
        bus.ctrl_MULT     = mul;
        bus.ctrl_DIV      = div;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(negedge clock);
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = 32'hDEAD_BEEF;
        bus.data_operandB = 32'h0;
    endtask

    task automatic wait_rdy(input string name, input int unsigned e0, input logic [31:0] exp_res,
                            input bit exp_exc, input int exp_lat);
        int n = 0;
        while (!bus.data_resultRDY && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (!bus.data_resultRDY) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: no ready pulse within 60 cycles, expected one", name);
        end else begin
            check({name, "_latency"}, edges - e0, 32'(exp_lat));
            check({name, "_result"}, bus.data_result, exp_res);
            check({name, "_exception"}, 32'(bus.data_exception), 32'(exp_exc));
        end
    endtask

    task automatic run_op(input string name, input bit mul, input bit div, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input bit exp_exc,
                          input int exp_lat);
        int unsigned e0;
        start_op(mul, div, a, b);
        e0 = edges;
        wait_rdy(name, e0, exp_res, exp_exc, exp_lat);
    endtask

    initial begin
        int unsigned e0;
        int rdy_seen;
        reset             = 1'b0;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (2) @(negedge clock);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_rdy", 32'(bus.data_resultRDY), 32'd0);
        check("reset_result", bus.data_result, 32'd0);
        check("reset_exception", 32'(bus.data_exception), 32'd0);
        reset  = 1'b1;
        chk_en = 1'b1;
        @(negedge clock);

        run_op("mul_7_m3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33);
        @(negedge clock);
        check("busy_after_rdy", 32'(bus.busy), 32'd0);
        run_op("mul_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, EarlyEn ? 20 : 33);
        run_op("div_m17_5", 1'b0, 1'b1, 32'hFFFF_FFEF, 32'd5, 32'hFFFF_FFFD, 1'b0, 33);
        run_op("div_9_0", 1'b0, 1'b1, 32'd9, 32'd0, 32'd0, 1'b1, 0);
        // Starts immediately while the previous op is in its ready cycle.
        run_op("div_minint_m1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33);
        run_op("div_100_m7", 1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, 33);
        run_op("div_m100_m7", 1'b0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 1'b0, 33);
        run_op("mul_both_hi", 1'b1, 1'b1, 32'd6, 32'd7, 32'd42, 1'b0, EarlyEn ? 6 : 33);
        run_op("mul_m1_m1", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 33);
        run_op("mul_max_2", 1'b1, 1'b0, 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1, EarlyEn ? 5 : 33);
        run_op("mul_5_1", 1'b1, 1'b0, 32'd5, 32'd1, 32'd5, 1'b0, EarlyEn ? 4 : 33);

        // Restart: a divide pulse ten edges into a multiply replaces it.
        start_op(1'b1, 1'b0, 32'd2, 32'd3);
        repeat (9) @(negedge clock);
        start_op(1'b0, 1'b1, 32'd100, 32'd7);
        e0 = edges;
        wait_rdy("abort_restart", e0, 32'd14, 1'b0, 33);

        // Reset in the middle of a multiply.
        start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        repeat (14) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check("midreset_busy", 32'(bus.busy), 32'd0);
        check("midreset_rdy", 32'(bus.data_resultRDY), 32'd0);
        check("midreset_result", bus.data_result, 32'd0);
        check("midreset_exception", 32'(bus.data_exception), 32'd0);
        rdy_seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.data_resultRDY) rdy_seen++;
        end
        check("no_rdy_after_reset", 32'(rdy_seen), 32'd0);
        run_op("mul_after_reset", 1'b1, 1'b0, 32'd3, 32'd4, 32'd12, 1'b0, EarlyEn ? 6 : 33);

        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected to have finished");
        $fatal(1, "watchdog expired");
    end
endmodule
